spi_cfg_sync: RTL and testbench
===============================

# spi_cfg_sync

Carries the AXI-domain configuration fields into the SPI clock domain and hands them to the SPI cores. It is the write-direction counterpart of the SPI status synchronizer. Each field passes through a multi-flop synchronizer with a stability check. A lock state machine freezes the configuration while the SPI subsystem is enabled and asserts `spi_en_stable` only after the frozen configuration is in place. The block sits at the AXI→SPI boundary, clocked by the SPI clock.

## Interface
- `SYNC_DEPTH`, default 3: synchronizer flop stages per field.
- `STABLE_COUNT`, default 2: consecutive equal samples required before a synchronizer's stable flag is raised.
- `MIN_WINDOW`, default 2048: minimum legal `integ_window` when integration is enabled.
- `clk`  in  1  SPI-domain clock (single clock; all logic on the rising edge).
- `aresetn`  in  1  asynchronous active-low reset.
- `spi_en`  in  1  AXI-domain SPI enable.
- `integ_en`  in  1  AXI-domain integrator enable.
- `integ_thresh_avg`  in  15  AXI-domain integrator average threshold.
- `integ_window`  in  32  AXI-domain integration window, in cycles.
- `dac_n_cs_high_time`  in  5  DAC chip-select high time.
- `adc_n_cs_high_time`  in  8  ADC chip-select high time.
- `spi_en_stable`  out  1  enable to the SPI cores.
- `integ_en_stable`, `integ_thresh_avg_stable`, `integ_window_stable`, `dac_n_cs_high_time_stable`, `adc_n_cs_high_time_stable`  out  1/15/32/5/8  configuration delivered to the SPI cores.
- `cfg_locked`  out  1  high while the configuration is frozen.
- `cfg_invalid`  out  1  an enable request was refused because the configuration is illegal.
- `cfg_changed`  out  1  sticky flag: an AXI-side config field changed while locked.

## Operation
- **Synchronizers:** one synchronizer instance per input, 6 total. Each produces `<field>_sync` and a stable flag. `all_stable` is the AND of the five config-field flags.
- **Validity check:** `invalid = integ_en_sync & (integ_window_sync < MIN_WINDOW)`. The comparison is 32-bit unsigned.
- **State IDLE** (reset state):
  - `spi_en_stable` = 0 and `cfg_locked` = 0.
  - Every cycle with `all_stable` = 1, each `*_stable` config output loads its `_sync` value. Otherwise the outputs hold.
  - `cfg_invalid` is registered from `all_stable & spi_en flag & spi_en_sync & invalid`.
  - Go to LOCK when `all_stable`, the spi_en flag, and `spi_en_sync` are all high and `invalid` is low. On that edge the config outputs load their final values and `cfg_locked` goes to 1.
- **State LOCK:**
  - Config outputs are frozen and `cfg_invalid` is held at 0.
  - `spi_en_stable` goes to 1 on the first edge after entry and stays at 1.
  - On any cycle where a field's stable flag is high and its `_sync` value differs from its frozen output, `cfg_changed` is set to 1 (sticky).
  - Go to IDLE when the spi_en flag is high and `spi_en_sync` = 0. On that edge `spi_en_stable`, `cfg_locked` and `cfg_changed` all go to 0. Config outputs resume tracking from the next cycle.
- **Reset:**
  - Asserting `aresetn` at any time, including mid-LOCK, asynchronously clears every output to 0 and forces IDLE.
  - The synchronizers also reset, so after release no lock is possible for at least SYNC_DEPTH+STABLE_COUNT cycles.
- **Simultaneous events:** if a config field becomes unstable in the same cycle `spi_en_sync` rises, the block stays in IDLE. Lock is retried on each later cycle where the conditions hold.

## Timing
- Input settled to `_sync` valid with flag high: at most SYNC_DEPTH+STABLE_COUNT cycles (5 with defaults).
- Flag high to `*_stable` config output updated: 1 cycle.
- `cfg_locked` rise to `spi_en_stable` rise: exactly 1 cycle. The configuration is always valid at least one cycle before the enable.
- Exit from LOCK: `spi_en_stable` falls on the same edge as `cfg_locked`, 1 cycle after the spi_en flag and sync conditions are met.
- An input toggling faster than STABLE_COUNT samples never raises its flag, so the affected outputs hold their previous values.

## Structure
- Shared package contents:
  - state encoding (IDLE=1'b0, LOCK=1'b1);
  - field-width constants (15/32/5/8);
  - `MIN_WINDOW` default.
- Sub-module: the existing `synchronizer` (parameters DEPTH, WIDTH, STABLE_COUNT; ports clk, aresetn, din, dout, stable), instantiated once per field.
- The FSM, compare and capture logic live in `spi_cfg_sync` itself.

## Test plan
- **Reset:** hold `aresetn`=0 with random inputs → every output reads 0. After release, no lock within 5 cycles.
- **Normal lock:** `integ_en`=1, `integ_window`=0x0001_0000, `integ_thresh_avg`=0x1000, `dac_n_cs_high_time`=3, `adc_n_cs_high_time`=10, then `spi_en`=1 → config outputs match the inputs; `cfg_locked`=1 within 7 cycles; `spi_en_stable`=1 exactly 1 cycle later.
- **Change while locked:** while locked, set `integ_window`=5 → `integ_window_stable` stays 0x0001_0000 and `cfg_changed`=1. Then drop `spi_en` → `spi_en_stable`, `cfg_locked` and `cfg_changed` clear on the same edge, and `integ_window_stable` becomes 5 one cycle later.
- **Illegal config:** `integ_en`=1, `integ_window`=100, `spi_en`=1 → stays IDLE, `cfg_invalid`=1, `spi_en_stable`=0. Change the window to 4096 → locks, `cfg_invalid`=0.
- **Unstable input:** toggle `adc_n_cs_high_time` between 0x55 and 0xAA every cycle with `spi_en`=1 → no lock, output holds its prior value. Stop toggling at 0xAA → output becomes 0xAA and the block locks.
- **Reset mid-lock:** pulse `aresetn` low mid-cycle during LOCK → all outputs 0 immediately, without waiting for a clock edge; IDLE after release.

Source files
------------

// File: rtl/spi_cfg_sync_pkg.sv
// Shared types and constants for the AXI-to-SPI configuration synchronizer.
package spi_cfg_sync_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int THRESH_W           = 15;
    localparam int WINDOW_W           = 32;
    localparam int DAC_CS_W           = 5;
    localparam int ADC_CS_W           = 8;
    localparam int MIN_WINDOW_DEFAULT = 2048;

endpackage

// File: rtl/spi_cfg_sync_synchronizer.sv
// Multi-flop synchronizer whose stable flag rises once the synchronized value
// has been sampled unchanged for STABLE_COUNT consecutive comparisons.
module synchronizer #(
    parameter int DEPTH        = 3,
    parameter int WIDTH        = 1,
    parameter int STABLE_COUNT = 2
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             stable
);

    localparam int CW = $clog2(STABLE_COUNT + 1);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [WIDTH-1:0] nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;

    // The value that becomes dout on the coming edge, compared against dout now.
    if (DEPTH == 1) begin : g_single
        assign nxt = din;
    end else begin : g_chain
        assign nxt = stage[DEPTH-2];
    end

    assign dout = stage[DEPTH-1];

    always_comb begin
        cnt_next = '0;
        if (nxt == dout) begin
            cnt_next = (cnt == CW'(STABLE_COUNT)) ? cnt : cnt + 1'b1;
        end
    end

    // NOTE: the synchronizer flops are reset too, so no stale pre-reset value
    // can look stable right after release.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            cnt    <= cnt_next;
            stable <= (cnt_next >= CW'(STABLE_COUNT));
        end
    end

endmodule

// File: rtl/spi_cfg_sync.sv
// Carries AXI-domain SPI configuration into the SPI clock domain and freezes it
// while the SPI subsystem is enabled.
module spi_cfg_sync
    import spi_cfg_sync_pkg::*;
#(
    parameter int SYNC_DEPTH   = 3,
    parameter int STABLE_COUNT = 2,
    parameter int MIN_WINDOW   = MIN_WINDOW_DEFAULT
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                spi_en,
    input  logic                integ_en,
    input  logic [THRESH_W-1:0] integ_thresh_avg,
    input  logic [WINDOW_W-1:0] integ_window,
    input  logic [DAC_CS_W-1:0] dac_n_cs_high_time,
    input  logic [ADC_CS_W-1:0] adc_n_cs_high_time,
    output logic                spi_en_stable,
    output logic                integ_en_stable,
    output logic [THRESH_W-1:0] integ_thresh_avg_stable,
    output logic [WINDOW_W-1:0] integ_window_stable,
    output logic [DAC_CS_W-1:0] dac_n_cs_high_time_stable,
    output logic [ADC_CS_W-1:0] adc_n_cs_high_time_stable,
    output logic                cfg_locked,
    output logic                cfg_invalid,
    output logic                cfg_changed
);

    logic                spi_en_sync,  spi_en_flag;
    logic                integ_en_sync, integ_en_flag;
    logic [THRESH_W-1:0] thresh_sync;
    logic                thresh_flag;
    logic [WINDOW_W-1:0] window_sync;
    logic                window_flag;
    logic [DAC_CS_W-1:0] dac_sync;
    logic                dac_flag;
    logic [ADC_CS_W-1:0] adc_sync;
    logic                adc_flag;

    synchronizer #(.DEPTH(SYNC_DEPTH), .WIDTH(1), .STABLE_COUNT(STABLE_COUNT)) u_sync_spi_en (
        .clk(clk), .aresetn(aresetn), .din(spi_en), .dout(spi_en_sync), .stable(spi_en_flag));
    synchronizer #(.DEPTH(SYNC_DEPTH), .WIDTH(1), .STABLE_COUNT(STABLE_COUNT)) u_sync_integ_en (
        .clk(clk), .aresetn(aresetn), .din(integ_en), .dout(integ_en_sync), .stable(integ_en_flag));
    synchronizer #(.DEPTH(SYNC_DEPTH), .WIDTH(THRESH_W), .STABLE_COUNT(STABLE_COUNT)) u_sync_thresh (
        .clk(clk), .aresetn(aresetn), .din(integ_thresh_avg), .dout(thresh_sync), .stable(thresh_flag));
    synchronizer #(.DEPTH(SYNC_DEPTH), .WIDTH(WINDOW_W), .STABLE_COUNT(STABLE_COUNT)) u_sync_window (
        .clk(clk), .aresetn(aresetn), .din(integ_window), .dout(window_sync), .stable(window_flag));
    synchronizer #(.DEPTH(SYNC_DEPTH), .WIDTH(DAC_CS_W), .STABLE_COUNT(STABLE_COUNT)) u_sync_dac (
        .clk(clk), .aresetn(aresetn), .din(dac_n_cs_high_time), .dout(dac_sync), .stable(dac_flag));
    synchronizer #(.DEPTH(SYNC_DEPTH), .WIDTH(ADC_CS_W), .STABLE_COUNT(STABLE_COUNT)) u_sync_adc (
        .clk(clk), .aresetn(aresetn), .din(adc_n_cs_high_time), .dout(adc_sync), .stable(adc_flag));

    state_t state;
    logic   all_stable;
    logic   invalid;
    logic   lock_req;
    logic   field_diff;

    assign all_stable = integ_en_flag & thresh_flag & window_flag & dac_flag & adc_flag;
    assign invalid    = integ_en_sync & (window_sync < WINDOW_W'(MIN_WINDOW));
    assign lock_req   = all_stable & spi_en_flag & spi_en_sync;

    // A field counts as changed only once its new value has settled.
    assign field_diff = (integ_en_flag && (integ_en_sync != integ_en_stable))
                      | (thresh_flag   && (thresh_sync   != integ_thresh_avg_stable))
                      | (window_flag   && (window_sync   != integ_window_stable))
                      | (dac_flag      && (dac_sync      != dac_n_cs_high_time_stable))
                      | (adc_flag      && (adc_sync      != adc_n_cs_high_time_stable));

    // NOTE: all state and outputs use non-blocking assignments so every branch
    // sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state                     <= IDLE;
            spi_en_stable             <= 1'b0;
            integ_en_stable           <= 1'b0;
            integ_thresh_avg_stable   <= '0;
            integ_window_stable       <= '0;
            dac_n_cs_high_time_stable <= '0;
            adc_n_cs_high_time_stable <= '0;
            cfg_locked                <= 1'b0;
            cfg_invalid               <= 1'b0;
            cfg_changed               <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (all_stable) begin
                        integ_en_stable           <= integ_en_sync;
                        integ_thresh_avg_stable   <= thresh_sync;
                        integ_window_stable       <= window_sync;
                        dac_n_cs_high_time_stable <= dac_sync;
                        adc_n_cs_high_time_stable <= adc_sync;
                    end
                    cfg_invalid <= lock_req & invalid;
                    if (lock_req && !invalid) begin
                        state      <= LOCK;
                        cfg_locked <= 1'b1;
                    end
                end
                LOCK: begin
                    cfg_invalid <= 1'b0;
                    if (spi_en_flag && !spi_en_sync) begin
                        state         <= IDLE;
                        spi_en_stable <= 1'b0;
                        cfg_locked    <= 1'b0;
                        cfg_changed   <= 1'b0;
                    end else begin
                        spi_en_stable <= 1'b1;
                        if (field_diff) cfg_changed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cfg_sync.sv
// Directed and randomized checks of spi_cfg_sync against a settle-and-compare
// reference model.
module tb_spi_cfg_sync;

    typedef struct packed {
        logic        en;
        logic [14:0] thresh;
        logic [31:0] window;
        logic [4:0]  dac;
        logic [7:0]  adc;
    } cfg_t;

    localparam int MIN_WIN = 2048;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        spi_en;
    logic        integ_en;
    logic [14:0] integ_thresh_avg;
    logic [31:0] integ_window;
    logic [4:0]  dac_n_cs_high_time;
    logic [7:0]  adc_n_cs_high_time;
    logic        spi_en_stable;
    logic        integ_en_stable;
    logic [14:0] integ_thresh_avg_stable;
    logic [31:0] integ_window_stable;
    logic [4:0]  dac_n_cs_high_time_stable;
    logic [7:0]  adc_n_cs_high_time_stable;
    logic        cfg_locked;
    logic        cfg_invalid;
    logic        cfg_changed;

    int n_tests = 0;
    int n_fail  = 0;

    spi_cfg_sync dut (
        .clk                       (clk),
        .aresetn                   (aresetn),
        .spi_en                    (spi_en),
        .integ_en                  (integ_en),
        .integ_thresh_avg          (integ_thresh_avg),
        .integ_window              (integ_window),
        .dac_n_cs_high_time        (dac_n_cs_high_time),
        .adc_n_cs_high_time        (adc_n_cs_high_time),
        .spi_en_stable             (spi_en_stable),
        .integ_en_stable           (integ_en_stable),
        .integ_thresh_avg_stable   (integ_thresh_avg_stable),
        .integ_window_stable       (integ_window_stable),
        .dac_n_cs_high_time_stable (dac_n_cs_high_time_stable),
        .adc_n_cs_high_time_stable (adc_n_cs_high_time_stable),
        .cfg_locked                (cfg_locked),
        .cfg_invalid               (cfg_invalid),
        .cfg_changed               (cfg_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Samples land 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_lock(input logic want, input int budget, output int cycles);
        cycles = 0;
        while (cfg_locked !== want && cycles < budget) begin
            step(1);
            cycles++;
        end
    endtask

    task automatic drive(input cfg_t c, input logic en);
        integ_en           = c.en;
        integ_thresh_avg   = c.thresh;
        integ_window       = c.window;
        dac_n_cs_high_time = c.dac;
        adc_n_cs_high_time = c.adc;
        spi_en             = en;
    endtask

    function automatic logic model_valid(input cfg_t c);
        return !(c.en && (c.window < 32'(MIN_WIN)));
    endfunction

    function automatic cfg_t delivered();
        cfg_t d;
        d.en     = integ_en_stable;
        d.thresh = integ_thresh_avg_stable;
        d.window = integ_window_stable;
        d.dac    = dac_n_cs_high_time_stable;
        d.adc    = adc_n_cs_high_time_stable;
        return d;
    endfunction

    function automatic logic [3:0] flags();
        return {spi_en_stable, cfg_locked, cfg_invalid, cfg_changed};
    endfunction

    initial begin
        cfg_t nominal, c;
        int   cyc;
        logic valid;

        nominal = '{en: 1'b1, thresh: 15'h1000, window: 32'h0001_0000, dac: 5'd3, adc: 8'd10};

        // Reset with random inputs: everything reads zero.
        aresetn = 1'b0;
        c = cfg_t'({$urandom, $urandom, $urandom});
        drive(c, 1'($urandom));
        step(3);
        check("rst_cfg", 64'(delivered()), 64'd0);
        check("rst_flags", 64'(flags()), 64'd0);

        // Release with a legal request pending: no lock in the first 5 cycles.
        drive(nominal, 1'b1);
        aresetn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            check($sformatf("rst_nolock_c%0d", i), 64'(cfg_locked), 64'd0);
        end
        wait_lock(1'b1, 10, cyc);
        check("rst_relock", 64'(cfg_locked), 64'd1);
        drive(nominal, 1'b0);
        wait_lock(1'b0, 12, cyc);
        check("rst_unlock", 64'(cfg_locked), 64'd0);

        // Normal lock.
        step(10);
        check("norm_track", 64'(delivered()), 64'(nominal));
        spi_en = 1'b1;
        wait_lock(1'b1, 7, cyc);
        check("norm_locked", 64'(cfg_locked), 64'd1);
        check("norm_en_lag", 64'(spi_en_stable), 64'd0);
        check("norm_cfg", 64'(delivered()), 64'(nominal));
        step(1);
        check("norm_en_rise", 64'(spi_en_stable), 64'd1);

        // Change while locked, then release.
        integ_window = 32'd5;
        step(8);
        check("chg_frozen", 64'(integ_window_stable), 64'h0001_0000);
        check("chg_flags", 64'(flags()), 64'b1101);
        spi_en = 1'b0;
        wait_lock(1'b0, 8, cyc);
        check("chg_unlock", 64'(flags()), 64'b0000);
        check("chg_hold", 64'(integ_window_stable), 64'h0001_0000);
        step(1);
        check("chg_resume", 64'(integ_window_stable), 64'd5);

        // Illegal configuration is refused until the window is widened.
        c = nominal;
        c.window = 32'd100;
        drive(c, 1'b1);
        step(12);
        check("ill_refused", 64'(flags()), 64'b0010);
        integ_window = 32'd4096;
        wait_lock(1'b1, 10, cyc);
        check("ill_locked", 64'(cfg_locked), 64'd1);
        check("ill_cleared", 64'(cfg_invalid), 64'd0);
        check("ill_window", 64'(integ_window_stable), 64'd4096);
        spi_en = 1'b0;
        wait_lock(1'b0, 10, cyc);
        check("ill_unlock", 64'(cfg_locked), 64'd0);

        // A toggling field blocks the lock and holds its output.
        c = nominal;
        c.en = 1'b0;
        c.adc = 8'h55;
        drive(c, 1'b0);
        step(10);
        check("tog_base", 64'(adc_n_cs_high_time_stable), 64'h55);
        spi_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            adc_n_cs_high_time = (i % 2 == 0) ? 8'hAA : 8'h55;
            step(1);
            if (i % 5 == 4) begin
                check($sformatf("tog_nolock_%0d", i), 64'(cfg_locked), 64'd0);
                check($sformatf("tog_hold_%0d", i), 64'(adc_n_cs_high_time_stable), 64'h55);
            end
        end
        adc_n_cs_high_time = 8'hAA;
        wait_lock(1'b1, 10, cyc);
        check("tog_locked", 64'(cfg_locked), 64'd1);
        check("tog_value", 64'(adc_n_cs_high_time_stable), 64'hAA);
        step(2);

        // Asynchronous reset in the middle of a cycle while locked.
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_cfg", 64'(delivered()), 64'd0);
        check("arst_flags", 64'(flags()), 64'd0);
        step(2);
        aresetn = 1'b1;
        step(4);
        check("arst_idle", 64'(flags()), 64'd0);
        wait_lock(1'b1, 10, cyc);
        check("arst_relock", 64'(cfg_locked), 64'd1);
        spi_en = 1'b0;
        wait_lock(1'b0, 10, cyc);
        check("arst_unlock", 64'(cfg_locked), 64'd0);

        // Randomized configurations against the settle-and-compare model.
        for (int k = 0; k < 10; k++) begin
            c.en     = 1'($urandom);
            c.thresh = 15'($urandom);
            c.window = $urandom_range(0, 1) ? 32'($urandom_range(0, 4095)) : $urandom;
            c.dac    = 5'($urandom);
            c.adc    = 8'($urandom);
            valid    = model_valid(c);
            drive(c, 1'b0);
            step(10);
            check($sformatf("rnd%0d_track", k), 64'(delivered()), 64'(c));
            spi_en = 1'b1;
            step(10);
            check($sformatf("rnd%0d_flags", k), 64'(flags()), 64'({valid, valid, ~valid, 1'b0}));
            check($sformatf("rnd%0d_cfg", k), 64'(delivered()), 64'(c));
            spi_en = 1'b0;
            step(10);
            check($sformatf("rnd%0d_off", k), 64'(flags()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
